fp_normalizer_pipe: RTL and testbench
=====================================

Name:
fp_normalizer_pipe

Overview:
- Pipelined, parametrised converter from a signed fixed-point accumulator sum plus a block scale exponent to a sign/exponent/mantissa floating-point word.
- Performs magnitude extraction, leading-one detection, normalising shift, round-to-nearest-even and exponent adjustment, with overflow/underflow handling.
- Sits after the MAC accumulator tree in the datapath. Uses a valid/ready handshake so downstream writeback can stall it.

Parameters:
SUM_W, 20, width of two's-complement input sum
FRAC_W, 10, fractional bits of the input sum (binary point position)
EXP_W, 5, exponent field width (in and out)
MAN_W, 10, stored mantissa width (hidden one not stored)
BIAS, 15, exponent bias

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input word valid
in_ready  out  1  block accepts input this cycle
in_sum  in  SUM_W  signed sum
in_exp  in  EXP_W  biased block exponent; value = in_sum * 2^(in_exp-BIAS-FRAC_W)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_sign  out  1  sign
out_exp  out  EXP_W  biased exponent
out_man  out  MAN_W  mantissa
out_ovf  out  1  result saturated to infinity
out_uf  out  1  result flushed to zero

Behaviour:
- Reset (rst=1 at a clk edge): all stage valids, out_valid, out_sign, out_exp, out_man, out_ovf and out_uf clear to 0. Reset mid-operation discards in-flight words. in_ready is 1 in the cycle after reset.
- Pipeline: 3 register stages; latency 3 cycles from an accepted input to out_valid with no stall.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv.
  - A word is accepted on in_valid && in_ready.
  - While adv=0, all stages hold and out_* remain stable.
  - No bubbles are inserted. Full throughput is 1 word per cycle.
- S1: register sign = in_sum[SUM_W-1] and mag = |in_sum| as SUM_W-bit unsigned. The most negative input gives mag = 2^(SUM_W-1), which is exact. Register in_exp.
- S2: p = index of the most significant 1 in mag (width clog2(SUM_W)). Register zero flag (mag==0), p, mag and exp.
- S3 exponent: e = in_exp + p - FRAC_W, computed signed with EXP_W+clog2(SUM_W)+1 bits.
- S3 mantissa, case p <= MAN_W: man = mag bits below the leading one, left-justified in MAN_W bits. The result is exact; no rounding.
- S3 mantissa, case p > MAN_W:
  - man = mag[p-1 : p-MAN_W].
  - guard = mag[p-MAN_W-1].
  - sticky = OR of the lower bits.
  - Round up iff guard && (sticky || man[0]).
  - If rounding overflows man (all ones + 1), then man = 0 and e = e+1.
- Special cases, in priority order:
  - zero: sign, exp, man all 0; ovf=uf=0. A negative zero is impossible.
  - e >= 2^EXP_W-1: ovf=1, exp all ones, man 0, sign kept.
  - e <= 0: uf=1, exp 0, man 0, sign kept. No subnormals.
  - otherwise: normal result.
- The flags are per-word and are valid only with out_valid.

Decomposition:
- Package fp_norm_pkg:
  - default parameter values (SUM_W, FRAC_W, EXP_W, MAN_W, BIAS);
  - clog2 constant function;
  - derived width localparams (POS_W, EXPC_W);
  - stage payload structs (s1_t, s2_t).
- One sub-module: leading_one_detector, parametrised by width. Purely combinational priority encoder, outputs pos and zero. Instantiated in S2.
- Rounding and exponent logic stay inline in S3.

Test Plan:
- in_sum=1024, in_exp=15 -> 3 cycles later: sign 0, exp 15, man 0, ovf=uf=0 (1.0).
- in_sum=-1536, in_exp=15 -> sign 1, exp 15, man 512 (-1.5).
- RNE cases, in_exp=15:
  - 2049 -> exp 16, man 0 (tie, even, round down).
  - 2051 -> exp 16, man 2 (tie, odd, round up).
  - 4095 -> exp 17, man 0 (carry-out).
- Boundaries:
  - in_sum=-524288, in_exp=15 -> sign 1, exp 24, man 0.
  - in_sum=524287, in_exp=30 -> ovf=1, exp 31, man 0.
  - in_sum=1, in_exp=0 -> uf=1, exp 0, man 0.
  - in_sum=0 -> all zero, no flags.
- Backpressure:
  - Stream 8 back-to-back words, holding out_ready=0 for 5 cycles mid-stream.
  - Required: out_* stable while stalled, in_ready=0 while out_valid && !out_ready.
  - Required: all 8 results delivered in order, none lost or duplicated.
- Assert rst for 1 cycle with 2 words in flight -> out_valid=0 on the next cycle; the in-flight words never appear; a new input afterwards emerges after 3 cycles.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared widths, helper function and stage payload types for the
// fixed-point to floating-point normaliser pipeline.
package fp_norm_pkg;

    localparam int SUM_W  = 20;  // two's-complement input sum width
    localparam int FRAC_W = 10;  // binary point position of the input sum
    localparam int EXP_W  = 5;   // exponent field width (in and out)
    localparam int MAN_W  = 10;  // stored mantissa width, hidden one excluded
    localparam int BIAS   = 15;  // exponent bias shared by input and output

    // Number of bits needed to index v distinct positions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int POS_W  = clog2(SUM_W);          // leading-one index width
    localparam int EXPC_W = EXP_W + POS_W + 1;     // signed exponent arithmetic width

    // Stage 1 payload: sign and magnitude split out of the sum.
    typedef struct packed {
        logic             sign;
        logic [SUM_W-1:0] mag;
        logic [EXP_W-1:0] exp;
    } s1_t;

    // Stage 2 payload: magnitude plus its leading-one position.
    typedef struct packed {
        logic             sign;
        logic             zero;
        logic [POS_W-1:0] pos;
        logic [SUM_W-1:0] mag;
        logic [EXP_W-1:0] exp;
    } s2_t;

endpackage

// File: rtl/fp_normalizer_pipe_if.sv
// Stream interface between the accumulator tree, the normaliser and writeback.
//
// Handshake: a word moves across a boundary on the rising clk edge where
// valid && ready are both 1. The sender holds valid and its payload stable
// until that edge; ready may depend on the receiver's own state but never on
// valid. in_* is the upstream boundary, out_* the downstream one.
interface fp_norm_if;
    import fp_norm_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [MAN_W-1:0] out_man;
    logic             out_ovf;
    logic             out_uf;

    modport master (
        output in_valid, in_sum, in_exp, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_man, out_ovf, out_uf
    );

    modport slave (
        input  in_valid, in_sum, in_exp, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_man, out_ovf, out_uf
    );

endinterface

// File: rtl/leading_one_detector.sv
// Combinational priority encoder: index of the most significant set bit.
module leading_one_detector #(
    parameter int W     = 20,
    parameter int POS_W = 5
) (
    input  logic [W-1:0]     vec,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        pos = '0;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) pos = POS_W'(i);
        end
    end

    assign zero = ~|vec;

endmodule

// File: rtl/fp_normalizer_pipe.sv
// Three-stage normaliser: signed fixed-point sum plus block exponent in,
// sign/exponent/mantissa float out, with round-to-nearest-even and
// saturation to infinity or flush to zero. One global enable stalls all
// stages together so no bubbles are created.
module fp_normalizer_pipe
    import fp_norm_pkg::*;
(
    input logic     clk,
    input logic     rst,
    fp_norm_if.slave bus
);

    localparam logic signed [EXPC_W-1:0] E_MAX = EXPC_W'((1 << EXP_W) - 1);
    localparam logic signed [EXPC_W-1:0] E_ONE = EXPC_W'(1);

    logic adv;
    logic v1, v2;
    s1_t  s1;
    s2_t  s2;

    logic [POS_W-1:0] lod_pos;
    logic             lod_zero;

    logic             out_valid_q, out_sign_q, out_ovf_q, out_uf_q;
    logic [EXP_W-1:0] out_exp_q;
    logic [MAN_W-1:0] out_man_q;

    // Stage 3 combinational results
    logic [POS_W-1:0]         sh;
    logic [SUM_W-2:0]         frac;
    logic [MAN_W-1:0]         man_t;
    logic                     guard, sticky, rnd;
    logic [MAN_W:0]           man_r;
    logic signed [EXPC_W-1:0] e_c;
    logic                     nx_sign, nx_ovf, nx_uf;
    logic [EXP_W-1:0]         nx_exp;
    logic [MAN_W-1:0]         nx_man;

    // The whole pipe moves whenever the output register is free or draining.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage 1: split sign and magnitude; the most negative sum maps to 2^(SUM_W-1).
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else if (adv) begin
            v1      <= bus.in_valid;
            s1.sign <= bus.in_sum[SUM_W-1];
            s1.mag  <= bus.in_sum[SUM_W-1] ? (~bus.in_sum + 1'b1) : bus.in_sum;
            s1.exp  <= bus.in_exp;
        end
    end

    leading_one_detector #(
        .W     (SUM_W),
        .POS_W (POS_W)
    ) u_lod (
        .vec  (s1.mag),
        .pos  (lod_pos),
        .zero (lod_zero)
    );

    // Stage 2: register the leading-one position alongside the magnitude.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
            s2 <= '0;
        end else if (adv) begin
            v2      <= v1;
            s2.sign <= s1.sign;
            s2.zero <= lod_zero;
            s2.pos  <= lod_pos;
            s2.mag  <= s1.mag;
            s2.exp  <= s1.exp;
        end
    end

    // Stage 3 datapath: shift the leading one out of the top, round RNE,
    // adjust the exponent and resolve zero/overflow/underflow.
    always_comb begin
        sh     = POS_W'(SUM_W - 1) - s2.pos;
        // Leading one lands just above frac and is dropped (hidden bit).
        frac   = (SUM_W-1)'(s2.mag << sh);
        man_t  = frac[SUM_W-2 -: MAN_W];
        // Small magnitudes shift in zeros here, so they never round.
        guard  = frac[SUM_W-2-MAN_W];
        sticky = |frac[SUM_W-3-MAN_W:0];
        rnd    = guard & (sticky | man_t[0]);
        man_r  = {1'b0, man_t} + {{MAN_W{1'b0}}, rnd};
        e_c    = $signed(EXPC_W'(s2.exp)) + $signed(EXPC_W'(s2.pos))
               - $signed(EXPC_W'(FRAC_W)) + $signed(EXPC_W'(man_r[MAN_W]));

        nx_sign = s2.sign;
        nx_exp  = e_c[EXP_W-1:0];
        nx_man  = man_r[MAN_W-1:0];
        nx_ovf  = 1'b0;
        nx_uf   = 1'b0;

        if (s2.zero) begin
            nx_sign = 1'b0;
            nx_exp  = '0;
            nx_man  = '0;
        end else if (e_c >= E_MAX) begin
            nx_ovf  = 1'b1;
            nx_exp  = '1;
            nx_man  = '0;
        end else if (e_c < E_ONE) begin
            nx_uf   = 1'b1;
            nx_exp  = '0;
            nx_man  = '0;
        end
    end

    // Stage 3 register doubles as the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_exp_q   <= '0;
            out_man_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_uf_q    <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v2;
            out_sign_q  <= nx_sign;
            out_exp_q   <= nx_exp;
            out_man_q   <= nx_man;
            out_ovf_q   <= nx_ovf;
            out_uf_q    <= nx_uf;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_man   = out_man_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_uf    = out_uf_q;

endmodule

// File: tb/tb_fp_normalizer_pipe.sv
// Directed bench for fp_normalizer_pipe: single-word vectors with exact
// latency, a stalled back-to-back stream, and reset with words in flight.
module tb_fp_normalizer_pipe;
    import fp_norm_pkg::*;

    localparam int NV = 18;
    localparam int RW = 1 + EXP_W + MAN_W + 2;

    logic clk;
    logic rst;

    fp_norm_if bus();

    fp_normalizer_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec;
    int n_err;

    int            vec_sum [NV];
    int            vec_exp [NV];
    logic [RW-1:0] vec_res [NV];
    logic [RW-1:0] exp_q[$];

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] pk(input logic s, input int e, input int m,
                                         input logic o, input logic u);
        return {s, EXP_W'(e), MAN_W'(m), o, u};
    endfunction

    function automatic logic [RW-1:0] obs();
        return {bus.out_sign, bus.out_exp, bus.out_man, bus.out_ovf, bus.out_uf};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_word(input int i);
        bus.in_valid = 1'b1;
        bus.in_sum   = SUM_W'(vec_sum[i]);
        bus.in_exp   = EXP_W'(vec_exp[i]);
    endtask

    // One isolated word: not visible after 2 edges, visible after the 3rd.
    task automatic send_one(input int i);
        @(negedge clk);
        drive_word(i);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 chk($sformatf("lat_early_%0d", i), bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk($sformatf("lat_valid_%0d", i), bus.out_valid, 1'b1);
        chk($sformatf("res_%0d", i), obs(), vec_res[i]);
    endtask

    // Eight back-to-back words with out_ready low for cycles 4..8.
    task automatic run_stream();
        int            sent;
        int            got;
        logic          stalled_prev;
        logic [RW-1:0] held;
        sent = 0;
        got = 0;
        stalled_prev = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 4 && cyc < 9);
            if (sent < 8) drive_word(sent);
            else bus.in_valid = 1'b0;
            #1;
            chk("bp_in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (bus.out_valid && !bus.out_ready) begin
                if (stalled_prev) chk("bp_hold", obs(), held);
                held = obs();
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("bp_extra", 1, 0);
                else chk($sformatf("bp_data_%0d", got), obs(), exp_q.pop_front());
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(vec_res[sent]);
                sent++;
            end
        end
        chk("bp_count", got, 8);
        chk("bp_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        vec_sum[0]  = 1024;    vec_exp[0]  = 15; vec_res[0]  = pk(0, 15, 0,   0, 0);
        vec_sum[1]  = -1536;   vec_exp[1]  = 15; vec_res[1]  = pk(1, 15, 512, 0, 0);
        vec_sum[2]  = 2049;    vec_exp[2]  = 15; vec_res[2]  = pk(0, 16, 0,   0, 0);
        vec_sum[3]  = 2051;    vec_exp[3]  = 15; vec_res[3]  = pk(0, 16, 2,   0, 0);
        vec_sum[4]  = 4095;    vec_exp[4]  = 15; vec_res[4]  = pk(0, 17, 0,   0, 0);
        vec_sum[5]  = -524288; vec_exp[5]  = 15; vec_res[5]  = pk(1, 24, 0,   0, 0);
        vec_sum[6]  = 524287;  vec_exp[6]  = 30; vec_res[6]  = pk(0, 31, 0,   1, 0);
        vec_sum[7]  = 1;       vec_exp[7]  = 0;  vec_res[7]  = pk(0, 0,  0,   0, 1);
        vec_sum[8]  = 0;       vec_exp[8]  = 15; vec_res[8]  = pk(0, 0,  0,   0, 0);
        vec_sum[9]  = -1;      vec_exp[9]  = 15; vec_res[9]  = pk(1, 5,  0,   0, 0);
        vec_sum[10] = 3;       vec_exp[10] = 15; vec_res[10] = pk(0, 6,  512, 0, 0);
        vec_sum[11] = -3;      vec_exp[11] = 0;  vec_res[11] = pk(1, 0,  0,   0, 1);
        vec_sum[12] = 524287;  vec_exp[12] = 15; vec_res[12] = pk(0, 24, 0,   0, 0);
        vec_sum[13] = 1024;    vec_exp[13] = 30; vec_res[13] = pk(0, 30, 0,   0, 0);
        vec_sum[14] = 1024;    vec_exp[14] = 31; vec_res[14] = pk(0, 31, 0,   1, 0);
        vec_sum[15] = 1024;    vec_exp[15] = 1;  vec_res[15] = pk(0, 1,  0,   0, 0);
        vec_sum[16] = 1024;    vec_exp[16] = 0;  vec_res[16] = pk(0, 0,  0,   0, 1);
        vec_sum[17] = 6147;    vec_exp[17] = 15; vec_res[17] = pk(0, 17, 513, 0, 0);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_payload", obs(), '0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_in_ready", bus.in_ready, 1'b1);

        for (int i = 0; i < NV; i++) send_one(i);

        repeat (2) @(negedge clk);
        run_stream();

        // Two words in flight, then a one-cycle reset.
        @(negedge clk);
        drive_word(0);
        @(negedge clk);
        drive_word(1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 chk("midrst_out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midrst_in_ready", bus.in_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 chk($sformatf("midrst_flushed_%0d", k), bus.out_valid, 1'b0);
        end
        send_one(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
